shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Multi-cycle controller that drives the datapath's single-position `shifter` to perform shifts of 0–15 positions on a 16-bit operand. A requester pulses `start` with operand, shift code and amount. The sequencer then iterates the shifter once per clock and returns the result with a one-cycle `done` pulse. It sits beside the ALU/shifter path and lets variable-amount shift instructions reuse the existing 1-bit shifter rather than adding a barrel shifter.

## Interface
- `AMT_W`, default 4: width of the shift-amount field; maximum amount is 2^AMT_W − 1.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe; sampled only in IDLE.
- `in`  in  16  operand.
- `shift`  in  2  shift code, same encoding as `shifter`:
  - 00: none
  - 01: left by 1, zero fill
  - 10: logical right by 1
  - 11: arithmetic right by 1
- `amount`  in  AMT_W  number of positions.
- `busy`  out  1  high from the cycle after an accepted `start` until `done` is asserted.
- `done`  out  1  one-cycle completion pulse.
- `sout`  out  16  registered result; holds its value until the next completion.

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE**
  - `start`=1: load the working register from `in`, latch `shift`, load the counter from `amount`.
  - Next state is DONE if `amount`==0 or `shift`==00; otherwise SHIFT.
  - `start`=0: remain in IDLE.
- **SHIFT** (each cycle)
  - Working register ← `shifter(work, shift_latched)`; counter decrements by 1.
  - When the counter is 1 (the last iteration), go to DONE.
- **DONE**
  - `sout` ← working register; `done`=1 for exactly this cycle.
  - Next state is IDLE unconditionally.
- `busy` = (state != IDLE) && (state != DONE); equivalently, `busy` is high only in SHIFT.
- `start` is ignored while in SHIFT or DONE; there is no queueing. A `start` in the cycle after DONE is accepted normally, since the FSM is back in IDLE.
- `in`, `shift` and `amount` are sampled only on the accepting edge and may change afterwards.
- The counter is AMT_W bits wide, decrements only in SHIFT, and never wraps: it exits at 1 and is never decremented from 0.
- Shift arithmetic is defined entirely by `shifter`:
  - Repeated left or logical-right shifts of 16 or more positions are not reachable with AMT_W=4.
  - Repeated arithmetic-right shifts saturate to all-sign bits.
- **Reset** (asynchronous, at any time, including mid-SHIFT):
  - State → IDLE.
  - `sout`=16'h0000, `busy`=0, `done`=0.
  - Counter and working register cleared.
  - Any in-flight operation is discarded with no `done` pulse.

## Timing
- `start` accepted at edge k with N = `amount`, where N>0 and `shift`≠00:
  - `busy`=1 during cycles k+1 … k+N.
  - `done`=1 and the new `sout` are visible in cycle k+N+1.
  - The FSM returns to IDLE at edge k+N+2.
- N=0 or `shift`=00: `done`=1 in cycle k+1, with `sout`=`in`; `busy` stays 0.
- Total latency from `start` to `done` is N+1 cycles; the minimum issue interval between accepted starts is N+2 cycles.
- `sout` changes only on the edge entering DONE, or on reset.
- The `shifter` instance is purely combinational between the working register and its next-state input, so there is no extra pipeline stage.

## Structure
- Shared package `shift_seq_pkg`:
  - enum `seq_state_t` {IDLE, SHIFT, DONE};
  - shift-code constants SH_NONE=2'b00, SH_LSL=2'b01, SH_LSR=2'b10, SH_ASR=2'b11.
- One sub-module: the existing `shifter` (ports `in`, `shift`, `sout`), instantiated once and fed by the working register and the latched shift code.
- All other logic lives in the top level: FSM, counter, working register and result register.

## Test plan
- **Reset:** assert `rst_n`=0 mid-run → `sout`=0000, `busy`=0, `done`=0 immediately. Deassert, then `start` with `in`=F0CF, `shift`=01, `amount`=1 → `done` 2 cycles later with `sout`=E19E.
- **Amount 4, all three shift codes**, with `in`=F0CF:
  - `shift`=01 → `sout`=0CF0;
  - `shift`=10 → `sout`=0F0C;
  - `shift`=11 → `sout`=FF0C.
  - Each case: `done` exactly 5 cycles after `start`, `busy` high for 4 cycles.
- **Zero cases:**
  - `amount`=0, `shift`=11, `in`=F0CF → `done` the next cycle, `sout`=F0CF, `busy` never high.
  - `shift`=00, `amount`=9 → same result and timing.
- **Maximum amount**, with `in`=8000 and `amount`=15:
  - `shift`=11 → `sout`=FFFF;
  - `shift`=10 → `sout`=0001.
  - Each case: `done` 16 cycles after `start`.
- **Busy protection:** during a `shift`=01, `amount`=8 run on 00FF, pulse `start` with different data at cycles 3 and 8 → both ignored; `sout`=FF00, exactly one `done` pulse. A `start` in the cycle after `done` is accepted.
- **Reset mid-SHIFT:** reset at cycle 3 of an amount-10 run → no `done` pulse, `sout`=0000. The next request completes correctly.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared definitions for the multi-cycle shift sequencer.
// Contents:
//   seq_state_t   FSM state encoding (IDLE, SHIFT, DONE)
//   SH_*          shift codes understood by the single-position shifter
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } seq_state_t;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

endpackage

// File: rtl/shifter.sv
// Single-position combinational shifter used by the datapath.
// Ports:
//   in    [15:0]  operand
//   shift [1:0]   00 none, 01 left zero fill, 10 logical right, 11 arithmetic right
//   sout  [15:0]  shifted operand
module shifter
  import shift_seq_pkg::*;
(
  input  logic [15:0] in,
  input  logic [1:0]  shift,
  output logic [15:0] sout
);

  always_comb begin
    sout = in;
    case (shift)
      SH_LSL:  sout = {in[14:0], 1'b0};
      SH_LSR:  sout = {1'b0, in[15:1]};
      SH_ASR:  sout = {in[15], in[15:1]};
      default: sout = in;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: performs 0..2^AMT_W-1 position shifts of a
// 16-bit operand by iterating the single-position shifter once per clock.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   request strobe, sampled only in IDLE
//   in      [15:0] operand
//   shift   [1:0]  shift code (shifter encoding)
//   amount  [AMT_W-1:0] number of positions
//   busy    high while iterating (SHIFT state)
//   done    one-cycle completion pulse
//   sout    [15:0] registered result, held until the next completion
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      in,
  input  logic [1:0]       shift,
  input  logic [AMT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [15:0]      sout
);

  seq_state_t       state_reg, state_next;
  logic [15:0]      work_reg, work_next;
  logic [15:0]      sout_reg, sout_next;
  logic [1:0]       code_reg, code_next;
  logic [AMT_W-1:0] count_reg, count_next;
  logic [15:0]      shifted;

  shifter u_shifter (
    .in    (work_reg),
    .shift (code_reg),
    .sout  (shifted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      work_reg  <= '0;
      sout_reg  <= '0;
      code_reg  <= SH_NONE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      work_reg  <= work_next;
      sout_reg  <= sout_next;
      code_reg  <= code_next;
      count_reg <= count_next;
    end
  end

  // The result register is loaded on the edge that enters DONE, so the new
  // value is already visible during the done pulse.
  always_comb begin
    state_next = state_reg;
    work_next  = work_reg;
    sout_next  = sout_reg;
    code_next  = code_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          work_next  = in;
          code_next  = shift;
          count_next = amount;
          if (amount == '0 || shift == SH_NONE) begin
            state_next = DONE;
            sout_next  = in;
          end else begin
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_next = shifted;
        // Never decrement from zero; a zero count cannot occur here but
        // is treated as the final iteration for safety.
        if (count_reg != '0) begin
          count_next = count_reg - AMT_W'(1);
        end
        if (count_reg <= AMT_W'(1)) begin
          state_next = DONE;
          sout_next  = shifted;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state_reg == SHIFT);
  assign done = (state_reg == DONE);
  assign sout = sout_reg;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] in_d;
  logic [1:0]  shift_d;
  logic [3:0]  amount_d;
  logic        busy;
  logic        done;
  logic [15:0] sout;

  int checks    = 0;
  int failures  = 0;
  int done_total = 0;
  int exp_done   = 0;

  logic [15:0] sb_q[$];

  typedef struct {
    logic [15:0] din;
    logic [1:0]  sh;
    logic [3:0]  amt;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[9];

  shift_sequencer #(.AMT_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .in     (in_d),
    .shift  (shift_d),
    .amount (amount_d),
    .busy   (busy),
    .done   (done),
    .sout   (sout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent count of every done pulse seen by the bench.
  always @(negedge clk) if (done === 1'b1) done_total++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] d, input logic [1:0] sh, input int n);
    logic [15:0] r;
    r = d;
    for (int i = 0; i < n; i++) begin
      case (sh)
        2'b01: r = r << 1;
        2'b10: r = r >> 1;
        2'b11: r = 16'($signed(r) >>> 1);
        default: r = r;
      endcase
    end
    return r;
  endfunction

  // Issue one request, then wait for its done pulse and check it.
  task automatic run_op(input string name, input logic [15:0] d, input logic [1:0] sh,
                        input logic [3:0] amt, input logic [15:0] exp_s);
    int cyc;
    int busy_cnt;
    bit got;
    int exp_lat;
    logic [15:0] exp_pop;
    exp_lat = (amt == 4'd0 || sh == 2'b00) ? 1 : int'(amt) + 1;
    @(negedge clk);
    start = 1'b1; in_d = d; shift_d = sh; amount_d = amt;
    sb_q.push_back(exp_s);
    @(negedge clk);
    // Scramble inputs: only the accepting edge may matter.
    start = 1'b0; in_d = ~d; shift_d = ~sh; amount_d = ~amt;
    cyc = 1; busy_cnt = 0; got = 0;
    while (cyc <= 40 && !got) begin
      if (done === 1'b1) begin
        got = 1;
        check({name, "_busy_in_done"}, {31'd0, busy}, 32'd0);
      end else begin
        if (busy === 1'b1) busy_cnt++;
        @(negedge clk);
        cyc++;
      end
    end
    check({name, "_got_done"}, {31'd0, got}, 32'd1);
    exp_pop = sb_q.pop_front();
    if (got) begin
      exp_done++;
      check({name, "_latency"}, cyc, exp_lat);
      check({name, "_busy_cycles"}, busy_cnt, exp_lat - 1);
      check({name, "_sout"}, {16'd0, sout}, {16'd0, exp_pop});
      @(negedge clk);
      check({name, "_done_single"}, {31'd0, done}, 32'd0);
      check({name, "_sout_hold"}, {16'd0, sout}, {16'd0, exp_pop});
    end
    $display("op %s in=%h sh=%b amt=%0d -> sout=%h lat=%0d busy=%0d", name, d, sh, amt, sout, cyc, busy_cnt);
  endtask

  initial begin
    int cyc;
    int busy_cnt;
    bit got;
    int snap;
    logic [15:0] r, exp_pop;
    logic [1:0]  rs;
    logic [3:0]  ra;

    vecs[0] = '{16'hF0CF, 2'b01, 4'd1,  16'hE19E};
    vecs[1] = '{16'hF0CF, 2'b01, 4'd4,  16'h0CF0};
    vecs[2] = '{16'hF0CF, 2'b10, 4'd4,  16'h0F0C};
    vecs[3] = '{16'hF0CF, 2'b11, 4'd4,  16'hFF0C};
    vecs[4] = '{16'hF0CF, 2'b11, 4'd0,  16'hF0CF};
    vecs[5] = '{16'hF0CF, 2'b00, 4'd9,  16'hF0CF};
    vecs[6] = '{16'h8000, 2'b11, 4'd15, 16'hFFFF};
    vecs[7] = '{16'h8000, 2'b10, 4'd15, 16'h0001};
    vecs[8] = '{16'h0001, 2'b01, 4'd15, 16'h8000};

    rst_n = 1'b1; start = 1'b0; in_d = '0; shift_d = '0; amount_d = '0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_sout", {16'd0, sout}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].din, vecs[i].sh, vecs[i].amt, vecs[i].exp);
    end

    // Random operations against the reference model
    for (int i = 0; i < 6; i++) begin
      r  = 16'($urandom);
      rs = 2'($urandom_range(0, 3));
      ra = 4'($urandom_range(0, 15));
      run_op($sformatf("rnd%0d", i), r, rs, ra, model(r, rs, int'(ra)));
    end

    // Busy protection: starts during SHIFT are ignored
    @(negedge clk);
    start = 1'b1; in_d = 16'h00FF; shift_d = 2'b01; amount_d = 4'd8;
    sb_q.push_back(16'hFF00);
    @(negedge clk);
    start = 1'b0;
    cyc = 1; busy_cnt = 0; got = 0;
    while (cyc <= 30 && !got) begin
      if (done === 1'b1) begin
        got = 1;
      end else begin
        if (busy === 1'b1) busy_cnt++;
        if (cyc == 3 || cyc == 8) begin
          start = 1'b1; in_d = 16'hABCD; shift_d = 2'b11; amount_d = 4'd2;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    check("busyprot_got_done", {31'd0, got}, 32'd1);
    exp_pop = sb_q.pop_front();
    if (got) exp_done++;
    check("busyprot_latency", cyc, 9);
    check("busyprot_busy_cycles", busy_cnt, 8);
    check("busyprot_sout", {16'd0, sout}, {16'd0, exp_pop});
    $display("op busyprot in=00ff sh=01 amt=8 -> sout=%h lat=%0d busy=%0d", sout, cyc, busy_cnt);
    // Back-to-back request in the cycle right after done
    run_op("after_done", 16'h1234, 2'b10, 4'd3, 16'h0246);

    // Reset mid-SHIFT discards the operation
    @(negedge clk);
    start = 1'b1; in_d = 16'hFFFF; shift_d = 2'b10; amount_d = 4'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_busy_before", {31'd0, busy}, 32'd1);
    snap = done_total;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_sout", {16'd0, sout}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_no_done", done_total, snap);
    check("midrst_sout_after", {16'd0, sout}, 32'd0);
    $display("op midreset in=ffff sh=10 amt=10 -> discarded sout=%h", sout);
    run_op("post_reset", 16'hF0CF, 2'b01, 4'd1, 16'hE19E);

    repeat (2) @(negedge clk);
    check("done_pulse_total", done_total, exp_done);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
